// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control sequencer for the RV32 core. Steps every instruction
// through FETCH -> DECODE -> EXECUTE -> WRITEBACK, owns the program counter
// and the instruction register, handshakes with a variable-latency
// instruction memory and gates the decode unit's register-file write enable
// so each instruction commits exactly once.
//
// Optional feature macro: SEQ_PERF_CNT_EN
//   defined     : cycle_count / instret_count are live 32-bit counters
//   not defined : both outputs tied to zero, no counter registers
//
// Parameters
//   RESET_PC      PC loaded on reset (bits [1:0] must be zero)
//   IMEM_TIMEOUT  FETCH cycles without imem_ack before FAULT (1..255)
//
// Ports
//   clk            in   core clock, rising edge
//   reset          in   asynchronous active-low reset
//   imem_req       out  instruction fetch request (FETCH only)
//   imem_addr      out  fetch address, always equal to pc
//   imem_ack       in   fetch data valid this cycle
//   imem_rdata     in   fetched instruction
//   instr          out  instruction register
//   ir_valid       out  instr holds a live instruction (DECODE/EXECUTE/WRITEBACK)
//   dec_write_en   in   raw register-file write enable from decode
//   rf_write_en    out  gated write enable, only in WRITEBACK
//   branch_taken   in   branch decision, sampled in EXECUTE
//   branch_target  in   branch target, sampled in EXECUTE
//   pc             out  program counter
//   halt           out  sticky, ECALL retired
//   fault          out  sticky, fetch timeout or misaligned branch target
//   cycle_count    out  live cycles (perf counter)
//   instret_count  out  retired instructions (perf counter)

module core_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        ir_valid,
  input  logic        dec_write_en,
  output logic        rf_write_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        halt,
  output logic        fault,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
  // Last wait-counter value before the timeout edge: the edge that would
  // make the counter equal IMEM_TIMEOUT goes to FAULT instead.
  localparam logic [7:0]  WAIT_LAST  = 8'(IMEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_wait;
  logic        r_br_taken;
  logic [31:0] r_br_target;

  // State-decoded output flags, registered alongside the state so they
  // change on the same edge as the state they describe.
  logic        r_imem_req;
  logic        r_ir_valid;
  logic        r_in_wb;
  logic        r_halt;
  logic        r_fault;

  logic        w_retire;

  // Next-state decision for the sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        // An ack in the timeout cycle wins over the timeout.
        if (imem_ack) begin
          w_next_state = S_DECODE;
        end else if (r_wait == WAIT_LAST) begin
          w_next_state = S_FAULT;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (r_instr == ECALL_WORD) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          w_next_state = S_FAULT;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_HALT:      w_next_state = S_HALT;
      S_FAULT:     w_next_state = S_FAULT;
      default:     w_next_state = S_FAULT;
    endcase
  end

  // Sequencer state, PC, instruction register, fetch wait counter and output flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_instr     <= 32'h0000_0000;
      r_wait      <= 8'd0;
      r_br_taken  <= 1'b0;
      r_br_target <= 32'h0000_0000;
      r_imem_req  <= 1'b1;
      r_ir_valid  <= 1'b0;
      r_in_wb     <= 1'b0;
      r_halt      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_imem_req <= (w_next_state == S_FETCH);
      r_ir_valid <= (w_next_state == S_DECODE) || (w_next_state == S_EXECUTE) ||
                    (w_next_state == S_WRITEBACK);
      r_in_wb    <= (w_next_state == S_WRITEBACK);
      r_halt     <= (w_next_state == S_HALT);
      r_fault    <= (w_next_state == S_FAULT);
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_wait  <= 8'd0;
          end else begin
            r_wait  <= r_wait + 8'd1;
          end
        end
        S_EXECUTE: begin
          r_br_taken  <= branch_taken;
          r_br_target <= branch_target;
        end
        S_WRITEBACK: begin
          // pc + 4 wraps naturally in 32 bits.
          r_pc <= r_br_taken ? r_br_target : (r_pc + 32'd4);
        end
        default: begin
          // DECODE holds everything; HALT/FAULT freeze pc and instr for debug.
        end
      endcase
    end
  end

  // An ECALL retires in DECODE, every other instruction in WRITEBACK.
  assign w_retire = (r_state == S_WRITEBACK) ||
                    ((r_state == S_DECODE) && (r_instr == ECALL_WORD));

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret_count;

  // Performance counters: live cycles and retired instructions, both wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_count   <= 32'h0000_0000;
      r_instret_count <= 32'h0000_0000;
    end else begin
      if ((r_state != S_HALT) && (r_state != S_FAULT)) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end else begin
        r_cycle_count <= r_cycle_count;
      end
      if (w_retire) begin
        r_instret_count <= r_instret_count + 32'd1;
      end else begin
        r_instret_count <= r_instret_count;
      end
    end
  end

  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign cycle_count     = 32'h0000_0000;
  assign instret_count   = 32'h0000_0000;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign ir_valid    = r_ir_valid;
  // The write enable is gated by a registered WRITEBACK flag, so it drops
  // together with an asynchronous reset.
  assign rf_write_en = r_in_wb & dec_write_en;
  assign halt        = r_halt;
  assign fault       = r_fault;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. The reference model is a
// per-instruction timeline: an instruction with fetch latency L occupies
// L+1 fetch cycles, then one decode, one execute and one writeback cycle;
// the model tracks the expected pc, cycle and retire counts arithmetically.

module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ECALL    = 32'h0000_0073;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        ir_valid;
  logic        dec_write_en;
  logic        rf_write_en;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        halt;
  logic        fault;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  core_sequencer #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .ir_valid(ir_valid),
    .dec_write_en(dec_write_en), .rf_write_en(rf_write_en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .halt(halt), .fault(fault),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cycle;
  logic [31:0] exp_instret;
  bit          live;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check every output at the falling edge of the current cycle.
  task automatic check_cycle(input string tag, input bit req, input bit vld,
                             input bit rf, input bit h, input bit f);
    @(negedge clk);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, vld});
    chk({tag, ".rf_write_en"}, {31'd0, rf_write_en}, {31'd0, rf});
    chk({tag, ".halt"}, {31'd0, halt}, {31'd0, h});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".imem_addr"}, imem_addr, exp_pc);
`ifdef SEQ_PERF_CNT_EN
    chk({tag, ".cycle_count"}, cycle_count, exp_cycle);
    chk({tag, ".instret_count"}, instret_count, exp_instret);
`else
    chk({tag, ".cycle_count"}, cycle_count, 32'h0000_0000);
    chk({tag, ".instret_count"}, instret_count, 32'h0000_0000);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    if (live) exp_cycle = exp_cycle + 32'd1;
    #1;
  endtask

  task automatic rand_inputs();
    imem_ack      = 1'($urandom);
    imem_rdata    = $urandom;
    dec_write_en  = 1'($urandom);
    branch_taken  = 1'($urandom);
    branch_target = $urandom;
  endtask

  task automatic model_reset();
    exp_pc      = RESET_PC;
    exp_cycle   = 32'd0;
    exp_instret = 32'd0;
    live        = 1'b1;
  endtask

  // Called just after a rising edge; leaves the bench at cycle 0 after release.
  task automatic do_reset();
    reset = 1'b0;
    rand_inputs();
    model_reset();
    @(negedge clk);
    chk("rst.pc", pc, RESET_PC);
    chk("rst.instr", instr, 32'h0000_0000);
    chk("rst.ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst.rf_write_en", {31'd0, rf_write_en}, 32'd0);
    chk("rst.halt", {31'd0, halt}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.cycle_count", cycle_count, 32'd0);
    chk("rst.instret_count", instret_count, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Terminal states: nothing may move, whatever the inputs do.
  task automatic hold_terminal(input string tag, input bit h, input bit f);
    for (int n = 0; n < 3; n++) begin
      rand_inputs();
      check_cycle(tag, 1'b0, 1'b0, 1'b0, h, f);
      next_cycle();
    end
  endtask

  task automatic run_instr(input logic [31:0] word, input int lat, input bit we,
                           input bit tk, input logic [31:0] tgt, input bit rst_in_exec);
    for (int k = 0; k <= lat; k++) begin
      rand_inputs();
      imem_ack   = (k == lat);
      imem_rdata = (k == lat) ? word : $urandom;
      check_cycle("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    rand_inputs();
    check_cycle("decode", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("decode.instr", instr, word);
    next_cycle();
    if (word == ECALL) begin
      live        = 1'b0;
      exp_instret = exp_instret + 32'd1;
      hold_terminal("halt", 1'b1, 1'b0);
      chk("halt.instr", instr, ECALL);
      return;
    end
    rand_inputs();
    branch_taken  = tk;
    branch_target = tgt;
    check_cycle("execute", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("execute.instr", instr, word);
    if (rst_in_exec) begin
      dec_write_en = 1'b1;
      reset        = 1'b0;
      #1;
      model_reset();
      chk("rst_exec.pc", pc, RESET_PC);
      chk("rst_exec.ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_exec.rf_write_en", {31'd0, rf_write_en}, 32'd0);
      chk("rst_exec.instr", instr, 32'h0000_0000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      return;
    end
    next_cycle();
    if (tk && (tgt[1:0] != 2'b00)) begin
      live = 1'b0;
      hold_terminal("misaligned", 1'b0, 1'b1);
      return;
    end
    rand_inputs();
    dec_write_en = we;
    check_cycle("writeback", 1'b0, 1'b1, we, 1'b0, 1'b0);
    chk("writeback.instr", instr, word);
    next_cycle();
    exp_instret = exp_instret + 32'd1;
    exp_pc      = tk ? tgt : (exp_pc + 32'd4);
  endtask

  task automatic run_timeout();
    for (int k = 0; k < TIMEOUT; k++) begin
      rand_inputs();
      imem_ack = 1'b0;
      check_cycle("timeout_wait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end
    live = 1'b0;
    hold_terminal("timeout_fault", 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == ECALL) w = w ^ 32'h0000_0100;
    return w;
  endfunction

  initial begin
    reset         = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0000_0000;
    dec_write_en  = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Zero-latency memory, three sequential instructions.
    for (int i = 0; i < 3; i++) run_instr(rand_word(), 0, 1'b1, 1'b0, 32'h0, 1'b0);
    // Ack delayed by 5 cycles.
    run_instr(rand_word(), 5, 1'b1, 1'b0, 32'h0, 1'b0);
    // Taken aligned branch.
    run_instr(rand_word(), 0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
    // Randomized instruction stream.
    for (int i = 0; i < 25; i++) begin
      run_instr(rand_word(), int'($urandom_range(0, 4)), 1'($urandom),
                ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, 1'b0);
    end
    // Ack in the last cycle before timeout still proceeds.
    run_instr(rand_word(), TIMEOUT - 1, 1'b1, 1'b0, 32'h0, 1'b0);
    // Reset during EXECUTE at an arbitrary pc.
    run_instr(rand_word(), 1, 1'b1, 1'b0, 32'h0, 1'b1);
    // PC wrap, then reset during EXECUTE of the next instruction.
    run_instr(rand_word(), 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_instr(rand_word(), 0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap.pc", pc, 32'h0000_0000);
    run_instr(rand_word(), 0, 1'b1, 1'b0, 32'h0, 1'b1);
    run_instr(rand_word(), 0, 1'b1, 1'b0, 32'h0, 1'b0);
    // Misaligned branch target.
    run_instr(rand_word(), 2, 1'b1, 1'b0, 32'h0, 1'b0);
    run_instr(rand_word(), 0, 1'b1, 1'b1, 32'h0000_0102, 1'b0);
    do_reset();
    // ECALL halts.
    run_instr(rand_word(), 0, 1'b1, 1'b0, 32'h0, 1'b0);
    run_instr(ECALL, 2, 1'b1, 1'b0, 32'h0, 1'b0);
    do_reset();
    // Fetch timeout.
    run_timeout();
    do_reset();
    run_instr(rand_word(), 3, 1'b1, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
